// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared widths, reset PC, queue entry and request FSM types for the fetch unit
package mp_pkg;

    localparam int MP_ADDR_W = 8;
    localparam int MP_DATA_W = 16;
    localparam logic [MP_ADDR_W-1:0] MP_RESET_PC = '0;

    // One prefetch queue entry: the fetched word tagged with the PC it came from
    typedef struct packed {
        logic [MP_ADDR_W-1:0] pc;
        logic [MP_DATA_W-1:0] word;
    } entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous prefetch FIFO with flush taking priority over push/pop
module ifu_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Entry storage: zeroed on reset so the head reads as zero, written on an accepted push
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; a flush empties the queue and ignores same-cycle push/pop
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit: single-outstanding memory requests feeding a prefetch queue
module ifu_prefetch
    import mp_pkg::*;
#(
    parameter int                ADDR_W   = MP_ADDR_W,
    parameter int                DATA_W   = MP_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(MP_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    req_state_t         r_state;
    req_state_t         w_next_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_discard;

    logic [CW-1:0]             w_count;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_ack;
    logic                      w_issue;
    logic [ADDR_W-1:0]         w_issue_pc;
    logic                      w_push;
    logic                      w_pop;
    logic [ADDR_W+DATA_W-1:0]  w_din;
    logic [ADDR_W+DATA_W-1:0]  w_dout;

    // An ack only means something while a request is actually outstanding
    assign w_ack = mem_ack && (r_state == ST_REQ);

    // Issuing reserves a queue slot: the in-flight word is guaranteed room when it lands.
    // A redirect clears the queue this cycle, so it also frees room and retargets the address.
    assign w_issue    = (r_state == ST_IDLE) && !halt && (redirect || (w_count < DEPTH_C));
    assign w_issue_pc = redirect ? redirect_pc : r_fetch_pc;

    assign w_push = w_ack && !r_discard && !redirect;
    assign w_pop  = !w_empty && instr_ready && !redirect;
    assign w_din  = {r_fetch_pc, mem_rdata};

    assign mem_addr    = r_addr;
    assign instr_valid = !w_empty;
    assign instr       = w_dout[DATA_W-1:0];
    assign instr_pc    = w_dout[ADDR_W+DATA_W-1:DATA_W];

    ifu_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .din   (w_din),
        .dout  (w_dout),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // Request FSM state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Request FSM next state: launch when allowed, complete on the memory ack
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_next_state = ST_REQ;
            ST_REQ:  if (mem_ack) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request FSM outputs: the request line is high for the whole outstanding period
    always_comb begin
        mem_req = (r_state == ST_REQ);
    end

    // Request address captured at launch and held until the ack
    always_ff @(posedge clk) begin
        if (!reset)       r_addr <= RESET_PC;
        else if (w_issue) r_addr <= w_issue_pc;
    end

    // Fetch PC and discard flag: redirect wins; a stale ack is swallowed without advancing the PC
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_discard  <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            if (w_ack)                    r_discard <= 1'b0;
            else if (r_state == ST_REQ)   r_discard <= 1'b1;
        end else if (w_ack) begin
            if (r_discard) r_discard  <= 1'b0;
            else           r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        end
    end

    // Slot reservation means a push can never meet a full queue
    always_ff @(posedge clk) begin
        if (reset) assert (!(w_push && w_full));
    end

endmodule
